multififo_drain_serializer: RTL and testbench

Downstream consumer of the 4-wide multi-word FIFO. Each cycle it issues a read of 0–4 words sized to what the FIFO holds and what its own staging ring can absorb. It captures the returned lanes and serializes them onto a single-word valid/ready stream. This converts the FIFO's bursty multi-lane output into a 1-word-per-cycle stream for single-lane datapaths.

---
 rtl/multififo_pkg.sv | 22 ++
 rtl/mw1r_ring.sv | 51 +++++
 rtl/multififo_drain_serializer.sv | 67 ++++++
 tb/tb_multififo_drain_serializer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/multififo_pkg.sv
// Shared definitions for the multi-word FIFO drain path: lane count, read sizing
// helper and parameter legality check.
package multififo_pkg;

    localparam int MAX_LANES = 4;

    // Smallest of three 16-bit counts, saturated to 0..MAX_LANES.
    function automatic logic [2:0] lanes_min(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [15:0] c);
        logic [15:0] m;
        m = (a < b) ? a : b;
        m = (m < c) ? m : c;
        if (m > 16'(MAX_LANES)) m = 16'(MAX_LANES);
        return m[2:0];
    endfunction

    function automatic bit buf_ok(input int depth);
        return (depth >= MAX_LANES) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/mw1r_ring.sv
// Staging ring: 4-lane variable-count write port, single-word read port.
// Owns the pointers and occupancy; storage itself is never cleared.
module mw1r_ring
    import multififo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BUF   = 8,
    localparam int PW   = $clog2(BUF),
    localparam int OW   = $clog2(BUF) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [2:0]                 push_cnt,
    input  logic [WIDTH*MAX_LANES-1:0] push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [OW-1:0]              occupancy
);

    logic [WIDTH-1:0] mem [BUF];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_LANES; k++) begin
            if (!clr && (3'(k) < push_cnt))
                mem[wptr + PW'(k)] <= push_data[WIDTH*k +: WIDTH];
        end
    end

    // Pointers wrap naturally at PW bits; push and pop are both applied in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else begin
            wptr      <= wptr + PW'(push_cnt);
            rptr      <= rptr + PW'(pop);
            occupancy <= occupancy + OW'(push_cnt) - OW'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/multififo_drain_serializer.sv
// Drains the 4-wide multi-word FIFO into a staging ring and serializes the
// ring onto a 1-word valid/ready stream.
module multififo_drain_serializer
    import multififo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BUF   = 8,
    localparam int OW   = $clog2(BUF) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       softreset,
    input  logic                       hold,
    input  logic [15:0]                fifo_count,
    output logic [2:0]                 reads,
    input  logic [WIDTH*MAX_LANES-1:0] fifo_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [OW-1:0]              occupancy,
    output logic [31:0]                words_out
);

    if (!buf_ok(BUF)) begin : g_bad_buf
        $error("BUF must be a power of two and at least MAX_LANES");
    end

    logic [OW-1:0] free_words;
    logic          pop;

    // Free space comes from registered occupancy only; a same-cycle pop is not credited.
    // Reads are also suppressed while rst_n is held low.
    assign free_words = OW'(BUF) - occupancy;

    always_comb begin
        reads = 3'd0;
        if (rst_n && !softreset && !hold)
            reads = lanes_min(16'(MAX_LANES), 16'(free_words), fifo_count);
    end

    assign out_valid = (occupancy != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            words_out <= '0;
        else if (softreset)
            words_out <= '0;
        else if (pop)
            words_out <= words_out + 32'd1;
    end

    mw1r_ring #(
        .WIDTH (WIDTH),
        .BUF   (BUF)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (softreset),
        .push_cnt  (reads),
        .push_data (fifo_dout),
        .pop       (pop),
        .head      (out_data),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_multififo_drain_serializer.sv
// Directed bench for multififo_drain_serializer (WIDTH=32, BUF=8) with
// hand-computed expected values.
module tb_multififo_drain_serializer;

    logic         clk;
    logic         rst_n;
    logic         softreset;
    logic         hold;
    logic [15:0]  fifo_count;
    logic [2:0]   reads;
    logic [127:0] fifo_dout;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [3:0]   occupancy;
    logic [31:0]  words_out;

    int n_vec = 0;
    int n_err = 0;

    multififo_drain_serializer #(.WIDTH(32), .BUF(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .softreset  (softreset),
        .hold       (hold),
        .fifo_count (fifo_count),
        .reads      (reads),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .words_out  (words_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] lanes(input logic [31:0] l3, input logic [31:0] l2,
                                           input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    initial begin
        rst_n      = 1'b0;
        softreset  = 1'b0;
        hold       = 1'b0;
        fifo_count = 16'd0;
        fifo_dout  = '0;
        out_ready  = 1'b0;
        #12;
        check("rst_occ",   32'(occupancy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_reads", 32'(reads),     32'd0);
        check("rst_words", words_out,      32'd0);
        cyc();
        rst_n = 1'b1;

        // single word
        fifo_count = 16'd1;
        fifo_dout  = lanes(32'h0, 32'h0, 32'h0, 32'hA5);
        out_ready  = 1'b1;
        #1 check("single_reads", 32'(reads), 32'd1);
        cyc();
        fifo_count = 16'd0;
        #1;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data",  out_data,       32'hA5);
        check("single_occ",   32'(occupancy), 32'd1);
        cyc();
        #1;
        check("single_words", words_out,      32'd1);
        check("single_occ0",  32'(occupancy), 32'd0);
        check("single_empty", 32'(out_valid), 32'd0);

        // burst fill with output blocked
        fifo_count = 16'd20;
        out_ready  = 1'b0;
        fifo_dout  = lanes(32'h103, 32'h102, 32'h101, 32'h100);
        #1 check("burst_reads0", 32'(reads), 32'd4);
        cyc();
        fifo_dout = lanes(32'h107, 32'h106, 32'h105, 32'h104);
        #1;
        check("burst_occ4",   32'(occupancy), 32'd4);
        check("burst_reads1", 32'(reads),     32'd4);
        cyc();
        #1;
        check("burst_occ8",   32'(occupancy), 32'd8);
        check("burst_reads2", 32'(reads),     32'd0);
        cyc();
        #1;
        check("burst_hold8",  32'(occupancy), 32'd8);
        check("burst_reads3", 32'(reads),     32'd0);
        check("burst_head",   out_data,       32'h100);

        // full while popping: no read credited for the pop
        out_ready = 1'b1;
        #1 check("full_pop_reads", 32'(reads), 32'd0);
        cyc();
        fifo_count = 16'd0;
        #1;
        check("pop_occ7",  32'(occupancy), 32'd7);
        check("pop_data1", out_data,       32'h101);
        cyc();
        #1;
        check("pop_occ6",  32'(occupancy), 32'd6);
        check("pop_data2", out_data,       32'h102);

        // simultaneous push and pop from occupancy 6
        fifo_count = 16'd9;
        fifo_dout  = lanes(32'hDEAD, 32'hBEEF, 32'h109, 32'h108);
        #1 check("pp_reads2", 32'(reads), 32'd2);
        cyc();
        fifo_dout = lanes(32'hDEAD, 32'hBEEF, 32'hCAFE, 32'h10A);
        #1;
        check("pp_occ7",   32'(occupancy), 32'd7);
        check("pp_reads1", 32'(reads),     32'd1);
        check("pp_data",   out_data,       32'h103);

        // hold rising mid-stream: no reads, output keeps draining
        cyc();
        fifo_count = 16'd5;
        hold       = 1'b1;
        #1;
        check("hold_reads", 32'(reads),     32'd0);
        check("hold_occ7",  32'(occupancy), 32'd7);
        check("hold_data0", out_data,       32'h104);
        cyc();
        #1;
        check("hold_occ6",  32'(occupancy), 32'd6);
        check("hold_data1", out_data,       32'h105);
        cyc();
        #1;
        check("hold_occ5",  32'(occupancy), 32'd5);
        check("hold_data2", out_data,       32'h106);
        check("hold_words", words_out,      32'd7);

        // softreset with occupancy 5
        hold      = 1'b0;
        softreset = 1'b1;
        #1 check("sr_reads", 32'(reads), 32'd0);
        cyc();
        softreset  = 1'b0;
        fifo_count = 16'd0;
        out_ready  = 1'b0;
        #1;
        check("sr_occ",   32'(occupancy), 32'd0);
        check("sr_valid", 32'(out_valid), 32'd0);
        check("sr_words", words_out,      32'd0);

        // move both pointers to 6, then push across the wrap
        fifo_count = 16'd4;
        fifo_dout  = '0;
        cyc();
        fifo_count = 16'd2;
        cyc();
        fifo_count = 16'd0;
        out_ready  = 1'b1;
        #1 check("wrap_pre_occ", 32'(occupancy), 32'd6);
        for (int i = 0; i < 6; i++) cyc();
        check("wrap_drained", 32'(occupancy), 32'd0);
        fifo_count = 16'd4;
        fifo_dout  = lanes(32'h13, 32'h12, 32'h11, 32'h10);
        #1 check("wrap_reads", 32'(reads), 32'd4);
        cyc();
        fifo_count = 16'd0;
        for (int i = 0; i < 4; i++) begin
            #1 check("wrap_data", out_data, 32'h10 + 32'(i));
            cyc();
        end
        check("wrap_empty", 32'(out_valid), 32'd0);
        check("wrap_words", words_out,      32'd10);

        // async reset mid-burst
        fifo_count = 16'd20;
        out_ready  = 1'b0;
        cyc();
        #1 check("ar_reads4", 32'(reads), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        check("ar_occ",   32'(occupancy), 32'd0);
        check("ar_reads", 32'(reads),     32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_words", words_out,      32'd0);
        #2 rst_n = 1'b1;
        fifo_count = 16'd0;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
